// File: rtl/syzygy_camera_capture.sv
// PHY-to-AXIS frame capture: armed by start_capture, captures N frames or runs continuously; beats reach axis_tvalid 2 clk after line_valid.
// Backpressure: axis_tready stalls the output FIFO; if the FIFO is full on a write, the rest of that frame is dropped and capture_overflow is raised.
module syzygy_camera_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

module syzygy_camera_capture #(
    parameter int LANES        = 4,
    parameter int PIX_IN_BITS  = 10,
    parameter int PIX_OUT_BITS = 8,
    parameter int FIFO_DEPTH   = 512,
    parameter int FCNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset_async_b,
    input  logic [LANES*PIX_IN_BITS-1:0]  pix_data,
    input  logic                          line_valid,
    input  logic                          sync_sof,
    input  logic                          sync_eof,
    input  logic                          sync_error,
    input  logic                          start_capture,
    input  logic [FCNT_W-1:0]             capture_frames,
    output logic [LANES*PIX_OUT_BITS-1:0] axis_tdata,
    output logic                          axis_tvalid,
    input  logic                          axis_tready,
    output logic                          axis_tuser,
    output logic                          axis_tlast,
    output logic                          capture_busy,
    output logic                          capture_done,
    output logic                          capture_overflow,
    output logic [FCNT_W-1:0]             frames_captured,
    output logic [7:0]                    num_frames,
    output logic [7:0]                    sync_error_count
);
    localparam int DW = LANES*PIX_OUT_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE, ST_DROP} state_e;

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [1:0]        start_sync_q;
    logic              start_prev_q;
    state_e            state_q, state_d;
    logic [FCNT_W-1:0] req_q, req_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              stop_q, stop_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              first_q, first_d;
    logic              stage_vld_q, stage_vld_d;
    logic [DW-1:0]     stage_dat_q, stage_dat_d;
    logic [7:0]        nframes_q;
    logic [7:0]        nerr_q;

    logic              start_edge, stop_now, pop, push, push_last, overflow_now;
    logic [FCNT_W-1:0] fcnt_inc;
    logic              fifo_push, fifo_empty, fifo_full;
    logic [DW+1:0]     fifo_dat;
    logic [DW-1:0]     pix_trunc;
    logic              pix_unused;

    // Release of reset is retimed to clk; assertion stays asynchronous.
    always_ff @(posedge clk or negedge reset_async_b) begin
        if (!reset_async_b) rst_sync_q <= 2'b00;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign pix_trunc[i*PIX_OUT_BITS +: PIX_OUT_BITS] =
            pix_data[i*PIX_IN_BITS + PIX_IN_BITS - 1 -: PIX_OUT_BITS];
    end
    assign pix_unused = ^pix_data;

    assign start_edge = start_sync_q[1] & ~start_prev_q;
    assign pop        = axis_tvalid & axis_tready;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        fcnt_d       = fcnt_q;
        stop_d       = stop_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        first_d      = first_q;
        stage_vld_d  = 1'b0;
        stage_dat_d  = stage_dat_q;
        push         = 1'b0;
        push_last    = 1'b0;
        overflow_now = 1'b0;
        fcnt_inc     = fcnt_q + 1'b1;
        stop_now     = stop_q | start_edge;
        if (state_q != ST_IDLE && start_edge) stop_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    req_d   = capture_frames;
                    fcnt_d  = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    stop_d  = 1'b0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (sync_sof) begin
                    if (stop_now) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_ACTIVE;
                        first_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                stage_vld_d  = line_valid & ~sync_eof;
                stage_dat_d  = pix_trunc;
                push         = stage_vld_q;
                push_last    = ~line_valid | sync_eof;
                overflow_now = push & fifo_full & ~pop;
                if (push && !overflow_now) first_d = 1'b0;
                if (overflow_now) begin
                    ovf_d       = 1'b1;
                    stage_vld_d = 1'b0;
                    state_d     = ST_DROP;
                end
                // A frame that overflows on its eof cycle still counts as dropped.
                if (sync_eof && !overflow_now) begin
                    fcnt_d = fcnt_inc;
                    if (((req_q != '0) && (fcnt_inc == req_q)) || stop_now) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = sync_sof ? ST_ACTIVE : ST_ARMED;
                        first_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_DROP || overflow_now) && sync_eof) begin
            if (((req_q == '0) || (fcnt_q < req_q)) && !stop_now) begin
                state_d = sync_sof ? ST_ACTIVE : ST_ARMED;
                first_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                stop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= 2'b00;
            start_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            req_q        <= '0;
            fcnt_q       <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            first_q      <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_dat_q  <= '0;
            nframes_q    <= '0;
            nerr_q       <= '0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_capture};
            start_prev_q <= start_sync_q[1];
            state_q      <= state_d;
            req_q        <= req_d;
            fcnt_q       <= fcnt_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            first_q      <= first_d;
            stage_vld_q  <= stage_vld_d;
            stage_dat_q  <= stage_dat_d;
            if (sync_sof) nframes_q <= nframes_q + 1'b1;
            if (sync_error && nerr_q != 8'hFF) nerr_q <= nerr_q + 1'b1;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign fifo_push = push & (~fifo_full | pop);

    syzygy_camera_fifo #(.W(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_dat_i ({first_q, push_last, stage_dat_q}),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign axis_tvalid = ~fifo_empty;
    assign {axis_tuser, axis_tlast, axis_tdata} = fifo_empty ? '0 : fifo_dat;

    assign capture_busy     = (state_q != ST_IDLE);
    assign capture_done     = done_q;
    assign capture_overflow = ovf_q;
    assign frames_captured  = fcnt_q;
    assign num_frames       = nframes_q;
    assign sync_error_count = nerr_q;
endmodule
